// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock, LSB first.
// Optional build macro SERIAL_SUBTRACTOR_SAT_EN clamps an underflowed result to zero.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int K  = WIDTH / DIGIT;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] b_next;
   logic             brw;
   logic             brw_next;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] part_next;
   logic             busy_next;
   logic             done_next;
   logic [WIDTH-1:0] diff_next;
   logic             borrow_next;
   logic [DIGIT:0]   digit;
   logic [WIDTH-1:0] shifted;

   // One digit of full-subtractor cells; the leading 1 makes the MSB the inverted borrow-out.
   function automatic logic [DIGIT:0] sub_digit(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y,
      input logic             bi
   );
      sub_digit = {1'b1, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
   endfunction

   // Next-state, datapath and output decode for the IDLE/RUN sequencer.
   always_comb begin
      state_next  = state;
      a_next      = a_sh;
      b_next      = b_sh;
      brw_next    = brw;
      cnt_next    = cnt;
      part_next   = part;
      busy_next   = busy;
      done_next   = 1'b0;
      diff_next   = diff;
      borrow_next = borrow;
      digit       = '0;
      shifted     = '0;
      case (state)
         IDLE: begin
            if (start) begin
               a_next     = a;
               b_next     = b;
               brw_next   = bin;
               cnt_next   = '0;
               part_next  = '0;
               busy_next  = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            digit     = sub_digit(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], brw);
            shifted   = (part >> DIGIT) | (WIDTH'(digit[DIGIT-1:0]) << (WIDTH - DIGIT));
            a_next    = a_sh >> DIGIT;
            b_next    = b_sh >> DIGIT;
            part_next = shifted;
            brw_next  = ~digit[DIGIT];
            if (cnt == CW'(K - 1)) begin
               cnt_next    = '0;
               state_next  = IDLE;
               busy_next   = 1'b0;
               done_next   = 1'b1;
               borrow_next = ~digit[DIGIT];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
               if (digit[DIGIT] == 1'b0) begin
                  diff_next = '0;
               end else begin
                  diff_next = shifted;
               end
`else
               diff_next = shifted;
`endif
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            cnt_next   = '0;
            brw_next   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         part   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         state  <= state_next;
         a_sh   <= a_next;
         b_sh   <= b_next;
         brw    <= brw_next;
         cnt    <= cnt_next;
         part   <= part_next;
         busy   <= busy_next;
         done   <= done_next;
         diff   <= diff_next;
         borrow <= borrow_next;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (8/1, 1/1, 16/4) with directed vectors.
// Expected diffs follow SERIAL_SUBTRACTOR_SAT_EN when the bench is built with that macro.
module tb_serial_subtractor;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic        start8 = 1'b0, bin8 = 1'b0, busy8, done8, borrow8;
   logic [7:0]  a8 = 8'h00, b8 = 8'h00, diff8;
   logic        start1 = 1'b0, bin1 = 1'b0, busy1, done1, borrow1;
   logic [0:0]  a1 = 1'b0, b1 = 1'b0, diff1;
   logic        start16 = 1'b0, bin16 = 1'b0, busy16, done16, borrow16;
   logic [15:0] a16 = 16'h0000, b16 = 16'h0000, diff16;

   exp_t q8[$];
   exp_t q1[$];
   exp_t q16[$];

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8));
   serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1));
   serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
      .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] sx(input logic [15:0] d, input logic bo);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      return bo ? 16'h0000 : d;
`else
      return d;
`endif
   endfunction

   // Monitors: pop and compare on every done; flag done pulses that never arrive.
   task automatic mon(input string nm, input logic dn, input logic bsy, input logic [15:0] d,
                      input logic bo, inout exp_t q[$]);
      exp_t e;
      if (q.size() > 0 && cyc > q[0].cyc) begin
         e = q.pop_front();
         check({nm, "_missing_done"}, 32'd0, 32'd1);
      end
      if (dn) begin
         if (q.size() == 0) begin
            check({nm, "_unexpected_done"}, 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check({nm, "_diff"}, {16'h0000, d}, {16'h0000, e.d});
            check({nm, "_borrow"}, {31'd0, bo}, {31'd0, e.bo});
            check({nm, "_latency"}, cyc, e.cyc);
            check({nm, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
         end
      end
   endtask

   always @(negedge clk) if (!rst) mon("w8", done8, busy8, {8'h00, diff8}, borrow8, q8);
   always @(negedge clk) if (!rst) mon("w1", done1, busy1, {15'h0000, diff1}, borrow1, q1);
   always @(negedge clk) if (!rst) mon("w16", done16, busy16, diff16, borrow16, q16);

   task automatic go8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                      input logic [7:0] ed, input logic eb);
      int n;
      n = 0;
      @(negedge clk);
      while (busy8 && n < 40) begin @(negedge clk); n++; end
      start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
      @(posedge clk); #1;
      q8.push_back('{sx({8'h00, ed}, eb), eb, cyc + 8});
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic go1(input logic ta, input logic tb, input logic tbin,
                      input logic ed, input logic eb);
      int n;
      n = 0;
      @(negedge clk);
      while (busy1 && n < 10) begin @(negedge clk); n++; end
      start1 = 1'b1; a1 = ta; b1 = tb; bin1 = tbin;
      @(posedge clk); #1;
      q1.push_back('{sx({15'h0000, ed}, eb), eb, cyc + 1});
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic go16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                       input logic [15:0] ed, input logic eb);
      int n;
      n = 0;
      @(negedge clk);
      while (busy16 && n < 40) begin @(negedge clk); n++; end
      start16 = 1'b1; a16 = ta; b16 = tb; bin16 = tbin;
      @(posedge clk); #1;
      q16.push_back('{sx(ed, eb), eb, cyc + 4});
      @(negedge clk);
      start16 = 1'b0;
   endtask

   task automatic wait_done8();
      int n;
      n = 0;
      while (!done8 && n < 40) begin @(negedge clk); n++; end
   endtask

   // Full-subtractor truth table {a,b,bin} -> {diff,borrow}
   logic [1:0] fs_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

   initial begin
      int cnt;
      int n;
      logic [2:0] idx;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy8}, 32'd0);
      check("rst_done", {31'd0, done8}, 32'd0);
      check("rst_diff", {24'd0, diff8}, 32'd0);
      check("rst_borrow", {31'd0, borrow8}, 32'd0);
      check("rst_diff16", {16'd0, diff16}, 32'd0);
      rst = 1'b0;

      // Basic subtraction with busy-length measurement
      go8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
      cnt = 0; n = 0;
      while (!done8 && n < 20) begin
         if (busy8) cnt++;
         @(negedge clk); n++;
      end
      check("busy8_cycles", cnt, 32'd8);

      // Underflow cases
      go8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      wait_done8();
      go8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
      wait_done8();

      // Start pulse while busy must be ignored
      go8(8'h40, 8'h11, 1'b0, 8'h2F, 1'b0);
      repeat (2) @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8();
      repeat (12) @(negedge clk);

      // Start held across done: second op accepted in the done cycle
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
      @(posedge clk); #1;
      q8.push_back('{sx(16'h007F, 1'b0), 1'b0, cyc + 8});
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1;
      wait_done8();
      @(posedge clk); #1;
      q8.push_back('{sx(16'h00EF, 1'b1), 1'b1, cyc + 8});
      check("b2b_accept_busy", {31'd0, busy8}, 32'd1);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_diff", {24'd0, diff8}, 32'h7F);
      check("hold_borrow", {31'd0, borrow8}, 32'd0);
      wait_done8();

      // Reset mid-operation
      go8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      q8.delete();
      #1;
      check("midrst_busy", {31'd0, busy8}, 32'd0);
      check("midrst_done", {31'd0, done8}, 32'd0);
      check("midrst_diff", {24'd0, diff8}, 32'd0);
      check("midrst_borrow", {31'd0, borrow8}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("postrst_idle", {31'd0, busy8}, 32'd0);
      go8(8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0);
      wait_done8();

      // Exhaustive 1-bit case
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         go1(idx[2], idx[1], idx[0], fs_tab[i][1], fs_tab[i][0]);
      end

      // Wider digit
      go16(16'h1234, 16'h0FFF, 1'b1, 16'h0234, 1'b0);
      go16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

      n = 0;
      while ((q8.size() + q1.size() + q16.size()) != 0 && n < 100) begin
         @(negedge clk); n++;
      end
      repeat (2) @(negedge clk);
      check("drain8", q8.size(), 32'd0);
      check("drain1", q1.size(), 32'd0);
      check("drain16", q16.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
